// File: rtl/gray_codec.sv
// gray_codec: binary/Gray converter and Gray up/down counter behind a one-deep valid/ready output register.
module gray_codec #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_q, valid_d, accept;
    logic [WIDTH-1:0] data_q, data_d, cnt_q, cnt_d, bin, res;
    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    // Gray-to-binary: bit i is the parity of every Gray bit at or above i
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) bin[i] = ^(in_data >> i);
    end
    always_comb begin
        res     = mode[1] ? cnt_q ^ (cnt_q >> 1) : mode[0] ? bin : in_data ^ (in_data >> 1);
        cnt_d   = accept && mode[1] ? (mode[0] ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1)) : cnt_q;
        valid_d = accept || (valid_q && !out_ready);
        data_d  = accept ? res : data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
